hazard_scoreboard: RTL

//  Parametrised successor of the pipeline hazard unit. Keeps a per-register scoreboard of pending long-latency writes
//  (loads, single multi-cycle MUL/DIV unit) and drives stall, flush, issue and N-source forwarding selects.

---
 rtl/hazard_pkg.sv | 18 +
 rtl/hazard_fwd_sel.sv | 28 ++
 rtl/hazard_scoreboard.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard.
//  ra_w()      : register-address width helper (at least 1 bit)
//  FWD_SEL_RF  : forwarding-select code meaning "read the register file"
//  mc_state_e  : multi-cycle unit occupancy state
package hazard_pkg;

  localparam int FWD_SEL_RF = 0;

  function automatic int ra_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Priority encoder choosing the forwarding source for one operand.
//  rs        in  source register address
//  fwd_valid in  per-source "holds a writing result"
//  fwd_rd    in  per-source destination register
//  sel       out 0 = register file, k = source k-1 (youngest match wins)
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int NUM_FWD = 2,
  parameter int RA_W    = 5,
  parameter int SEL_W   = 2
) (
  input  logic [RA_W-1:0]               rs,
  input  logic [NUM_FWD-1:0]            fwd_valid,
  input  logic [NUM_FWD-1:0][RA_W-1:0]  fwd_rd,
  output logic [SEL_W-1:0]              sel
);

  // Walk from oldest to youngest so the lowest index overwrites last.
  always_comb begin
    sel = SEL_W'(FWD_SEL_RF);
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_valid[k] && (fwd_rd[k] == rs) && (rs != '0))
        sel = SEL_W'(k + 1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks pending load / multi-cycle writes per
// register and produces stall, flush, issue and forwarding selects for ID.
//  clk, rst                 clock, asynchronous active-high reset
//  id_*                     decode info of the instruction in ID
//  ex_branch_taken          taken branch resolved in EX (redirect)
//  fwd_valid / fwd_rd       forwarding taps, index 0 = youngest
//  ld_done_* / mc_done_*    completion of pending load / multi-cycle writes
//  stall_if, stall_id       hold PC and IF/ID
//  flush_if_id, flush_id_ex squash IF/ID, bubble into ID/EX
//  id_issue                 ID instruction advances this cycle
//  fwd_sel_a / fwd_sel_b    0 = register file, k = forwarding source k-1
//  mc_busy, hazard_err      MC unit occupied; sticky protocol/timeout error
// Build option HAZARD_PERF_CNT_EN adds perf_stall_cnt / perf_flush_cnt
// (saturating counts of stall_id and flush_if_id cycles).
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int  NUM_REGS   = 32,
  parameter int  NUM_FWD    = 2,
  parameter int  MC_MAX_LAT = 34,
  localparam int RA_W       = ra_w(NUM_REGS),
  localparam int SEL_W      = $clog2(NUM_FWD + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [RA_W-1:0]         id_rs1_addr,
  input  logic [RA_W-1:0]         id_rs2_addr,
  input  logic                    id_uses_rs1,
  input  logic                    id_uses_rs2,
  input  logic [RA_W-1:0]         id_rd_addr,
  input  logic                    id_reg_write_en,
  input  logic                    id_is_load,
  input  logic                    id_is_mc,
  input  logic                    id_jump_inst,
  input  logic                    ex_branch_taken,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD*RA_W-1:0] fwd_rd,
  input  logic                    ld_done_valid,
  input  logic [RA_W-1:0]         ld_done_rd,
  input  logic                    mc_done_valid,
  input  logic [RA_W-1:0]         mc_done_rd,
  output logic                    stall_if,
  output logic                    stall_id,
  output logic                    flush_if_id,
  output logic                    flush_id_ex,
  output logic                    id_issue,
  output logic [SEL_W-1:0]        fwd_sel_a,
  output logic [SEL_W-1:0]        fwd_sel_b,
  output logic                    mc_busy,
  output logic                    hazard_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]             perf_stall_cnt,
  output logic [31:0]             perf_flush_cnt
`endif
);

  localparam int CNT_W = $clog2(MC_MAX_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MC_MAX_LAT);

  logic [NUM_REGS-1:0] busy_q, busy_d, busy_eff, done_clr;
  mc_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  logic raw1, raw2, waw, struct_stall, stall, mc_issue;

  // ---------------- forwarding selects ----------------
  logic [NUM_FWD-1:0][RA_W-1:0] fwd_rd_p;
  logic [1:0][RA_W-1:0]         op_rs;
  logic [1:0][SEL_W-1:0]        op_sel;

  assign fwd_rd_p = fwd_rd;
  assign op_rs[0] = id_rs1_addr;
  assign op_rs[1] = id_rs2_addr;

  for (genvar g = 0; g < 2; g++) begin : g_op
    hazard_fwd_sel #(
      .NUM_FWD (NUM_FWD),
      .RA_W    (RA_W),
      .SEL_W   (SEL_W)
    ) u_fwd_sel (
      .rs        (op_rs[g]),
      .fwd_valid (fwd_valid),
      .fwd_rd    (fwd_rd_p),
      .sel       (op_sel[g])
    );
  end

  // ---------------- hazard detection ----------------
  // A register whose result lands this cycle is forwarded, not stalled on.
  always_comb begin
    done_clr = '0;
    if (ld_done_valid) done_clr[ld_done_rd] = 1'b1;
    if (mc_done_valid) done_clr[mc_done_rd] = 1'b1;
  end

  assign busy_eff = busy_q & ~done_clr;

  assign raw1 = id_valid & id_uses_rs1 & (id_rs1_addr != '0) & busy_eff[id_rs1_addr];
  assign raw2 = id_valid & id_uses_rs2 & (id_rs2_addr != '0) & busy_eff[id_rs2_addr];
  assign waw  = id_reg_write_en & (id_rd_addr != '0) & busy_eff[id_rd_addr];
  assign struct_stall = id_is_mc & (state_q == MC_BUSY) & ~mc_done_valid;
  assign stall = raw1 | raw2 | waw | struct_stall;

  // Internal issue: an EX redirect kills the ID instruction regardless of stall.
  logic issue_int;
  assign issue_int = id_valid & ~stall & ~ex_branch_taken;
  assign mc_issue  = issue_int & id_is_mc;

  // Outputs are forced low while reset is asserted.
  always_comb begin
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    id_issue    = 1'b0;
    fwd_sel_a   = '0;
    fwd_sel_b   = '0;
    if (!rst) begin
      stall_if    = stall & ~ex_branch_taken;
      stall_id    = stall & ~ex_branch_taken;
      flush_if_id = ex_branch_taken | id_jump_inst;
      flush_id_ex = stall | ex_branch_taken;
      id_issue    = issue_int;
      fwd_sel_a   = op_sel[0];
      fwd_sel_b   = op_sel[1];
    end
  end

  assign mc_busy    = ~rst & (state_q == MC_BUSY);
  assign hazard_err = ~rst & err_q;

  // ---------------- scoreboard ----------------
  // Clear first, then set: a new write to the same rd outranks its completion.
  always_comb begin
    busy_d = busy_q & ~done_clr;
    if (issue_int && (id_is_load || id_is_mc) && (id_rd_addr != '0))
      busy_d[id_rd_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // ---------------- multi-cycle unit FSM ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      MC_IDLE: begin
        if (mc_done_valid) err_d = 1'b1;  // completion with nothing outstanding
        if (mc_issue) begin
          state_d = MC_BUSY;
          cnt_d   = '0;
        end
      end
      MC_BUSY: begin
        if (mc_done_valid) begin
          cnt_d   = '0;
          state_d = mc_issue ? MC_BUSY : MC_IDLE;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_MAX) err_d = 1'b1;
        end
      end
      default: state_d = MC_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= '0;
      state_q <= MC_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // ---------------- performance counters (saturating) ----------------
  logic [31:0] perf_stall_q, perf_stall_d, perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (stall_id    && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
    if (flush_if_id && (perf_flush_q != '1)) perf_flush_d = perf_flush_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
